// File: rtl/half_adder_pkg.sv
// Shared constants for the pipelined multi-lane half adder.
// Holds the pipeline depth bound and the reset value of every stage register.
package half_adder_pkg;

  localparam int   MAX_STAGES = 4;
  localparam logic RST_VAL    = 1'b0;

  // A depth is legal when it lies in 1..MAX_STAGES.
  function automatic logic stages_legal(input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One combinational 1-bit half-adder lane.
// Produces sum = a XOR b and carry = a AND b.
module half_adder_lane
  import half_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes followed by a STAGES-deep output pipeline.
// Stage 1 captures only qualified inputs; later stages shift unconditionally.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             carry_any
);

  // Out-of-range depths fall back to the nearest legal value.
  localparam int DEPTH = stages_legal(STAGES) ? STAGES :
                         ((STAGES < 1) ? 1 : MAX_STAGES);

  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_cry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a_i (a[i]),
      .b_i (b[i]),
      .s_o (lane_sum[i]),
      .c_o (lane_cry[i])
    );
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             v_q, v_d;
    logic             any_q, any_d;

    if (g == 0) begin : g_first
      // Capture a new result on a qualified edge, otherwise hold the last one.
      always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        any_d = any_q;
        v_d   = in_valid;
        if (in_valid) begin
          s_d   = lane_sum;
          c_d   = lane_cry;
          any_d = |lane_cry;
        end else begin
          s_d   = s_q;
          c_d   = c_q;
          any_d = any_q;
        end
      end
    end else begin : g_shift
      assign s_d   = g_stage[g-1].s_q;
      assign c_d   = g_stage[g-1].c_q;
      assign v_d   = g_stage[g-1].v_q;
      assign any_d = g_stage[g-1].any_q;
    end

    // Stage register; reset discards whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q   <= {WIDTH{RST_VAL}};
        c_q   <= {WIDTH{RST_VAL}};
        v_q   <= RST_VAL;
        any_q <= RST_VAL;
      end else begin
        s_q   <= s_d;
        c_q   <= c_d;
        v_q   <= v_d;
        any_q <= any_d;
      end
    end
  end

  assign s         = g_stage[DEPTH-1].s_q;
  assign c         = g_stage[DEPTH-1].c_q;
  assign out_valid = g_stage[DEPTH-1].v_q;
  assign carry_any = g_stage[DEPTH-1].any_q;

endmodule

// File: tb/tb_half_adder.sv
// Randomised self-checking bench: one 1-lane/1-stage instance and four 8-lane
// instances with depths 1..4, all compared every cycle against an input-history model.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic s1, c1, ov1, ca1;

  half_adder #(.WIDTH(1), .STAGES(1)) u_dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .s         (s1),
    .c         (c1),
    .out_valid (ov1),
    .carry_any (ca1)
  );

  logic [7:0] s_w  [1:4];
  logic [7:0] c_w  [1:4];
  logic       ov_w [1:4];
  logic       ca_w [1:4];

  for (genvar k = 1; k <= 4; k++) begin : g_dut
    half_adder #(.WIDTH(8), .STAGES(k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s_w[k]),
      .c         (c_w[k]),
      .out_valid (ov_w[k]),
      .carry_any (ca_w[k])
    );
  end

  // Inputs sampled on each rising edge since the last reset release.
  logic       hv[$];
  logic [7:0] ha[$];
  logic [7:0] hb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output of a depth-k pipeline: the most recent valid sample taken at or
  // before the edge k-1 edges ago; valid only if that very edge was qualified.
  function automatic void model(input int k, output logic v, output logic [7:0] es,
                                output logic [7:0] ec, output logic eany);
    int idx;
    int sum;
    idx  = hv.size() - k;
    v    = 1'b0;
    es   = 8'h00;
    ec   = 8'h00;
    eany = 1'b0;
    if (idx >= 0) v = hv[idx];
    for (int j = idx; j >= 0; j--) begin
      if (hv[j]) begin
        for (int i = 0; i < 8; i++) begin
          sum   = int'(ha[j][i]) + int'(hb[j][i]);
          es[i] = (sum % 2) != 0;
          ec[i] = sum >= 2;
        end
        eany = (ec != 8'h00);
        break;
      end
    end
  endfunction

  task automatic check_all();
    logic       v;
    logic [7:0] es, ec;
    logic       eany;
    for (int k = 1; k <= 4; k++) begin
      model(k, v, es, ec, eany);
      check_eq($sformatf("s_d%0d", k),   32'(s_w[k]),  32'(es));
      check_eq($sformatf("c_d%0d", k),   32'(c_w[k]),  32'(ec));
      check_eq($sformatf("ov_d%0d", k),  32'(ov_w[k]), 32'(v));
      check_eq($sformatf("any_d%0d", k), 32'(ca_w[k]), 32'(eany));
    end
    model(1, v, es, ec, eany);
    check_eq("s_w1",   32'(s1),  32'(es[0]));
    check_eq("c_w1",   32'(c1),  32'(ec[0]));
    check_eq("ov_w1",  32'(ov1), 32'(v));
    check_eq("any_w1", 32'(ca1), 32'(ec[0]));
  endtask

  task automatic check_zero(input string tag);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("%s_s%0d", tag, k),   32'(s_w[k]),  32'd0);
      check_eq($sformatf("%s_c%0d", tag, k),   32'(c_w[k]),  32'd0);
      check_eq($sformatf("%s_ov%0d", tag, k),  32'(ov_w[k]), 32'd0);
      check_eq($sformatf("%s_any%0d", tag, k), 32'(ca_w[k]), 32'd0);
    end
    check_eq({tag, "_w1"}, {28'd0, s1, c1, ov1, ca1}, 32'd0);
  endtask

  task automatic clear_history();
    hv.delete();
    ha.delete();
    hb.delete();
  endtask

  // Drive one input vector, take one edge, then compare every instance.
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    hv.push_back(v);
    ha.push_back(av);
    hb.push_back(bv);
    #1;
    check_all();
  endtask

  task automatic step_rand(input logic v);
    step(v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  logic [1:0] tt_exp [4];
  logic [7:0] tt_a, tt_b;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    tt_exp   = '{2'b00, 2'b01, 2'b01, 2'b10};

    #3;
    check_zero("rst_init");
    #9;
    rst = 1'b0;
    clear_history();

    // Truth table on lane 0; {c,s} one edge later.
    for (int t = 0; t < 4; t++) begin
      tt_a = {7'h00, 1'(t >> 1)};
      tt_b = {7'h00, 1'(t & 1)};
      step(1'b1, tt_a, tt_b);
      check_eq($sformatf("tt%0d_w1", t), {30'd0, c1, s1}, {30'd0, tt_exp[t]});
    end
    for (int t = 0; t < 5; t++) step(1'b0, 8'h00, 8'h00);

    // Single pulse: out_valid exactly STAGES edges later, for one cycle.
    step(1'b1, 8'hFF, 8'hFF);
    for (int t = 1; t <= 6; t++) begin
      if (t > 1) step(1'b0, 8'h00, 8'h00);
      for (int k = 1; k <= 4; k++) begin
        check_eq($sformatf("lat_ov_d%0d_t%0d", k, t), 32'(ov_w[k]), 32'(t == k));
        if (t == k) begin
          check_eq($sformatf("lat_c_d%0d", k), 32'(c_w[k][0]), 32'd1);
          check_eq($sformatf("lat_s_d%0d", k), 32'(s_w[k][0]), 32'd0);
        end
      end
    end

    // Multi-lane patterns.
    step(1'b1, 8'hF0, 8'hCC);
    check_eq("ml1_s",   32'(s_w[1]),  32'h3C);
    check_eq("ml1_c",   32'(c_w[1]),  32'hC0);
    check_eq("ml1_any", 32'(ca_w[1]), 32'd1);
    step(1'b1, 8'h0F, 8'hF0);
    check_eq("ml2_s",   32'(s_w[1]),  32'hFF);
    check_eq("ml2_c",   32'(c_w[1]),  32'h00);
    check_eq("ml2_any", 32'(ca_w[1]), 32'd0);

    // Hold: unqualified inputs must not disturb the held result.
    step(1'b1, 8'h01, 8'h01);
    step(1'b0, 8'h00, 8'h01);
    check_eq("hold_s",  32'(s_w[1][0]), 32'd0);
    check_eq("hold_c",  32'(c_w[1][0]), 32'd1);
    check_eq("hold_ov", 32'(ov_w[1]),   32'd0);
    for (int t = 0; t < 4; t++) step(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Throughput: 16 back-to-back valid vectors.
    for (int t = 0; t < 16; t++) begin
      step_rand(1'b1);
      if (t >= 3) check_eq($sformatf("tput_ov_t%0d", t), 32'(ov_w[4]), 32'd1);
    end
    for (int t = 0; t < 5; t++) step_rand(1'b0);

    // Asynchronous reset with results in flight.
    step_rand(1'b1);
    step_rand(1'b1);
    step_rand(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    #2;
    rst = 1'b0;
    clear_history();
    for (int t = 0; t < 6; t++) step_rand(1'b0);

    // Mixed random traffic.
    for (int t = 0; t < 60; t++) step_rand(1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent 1-bit half-adder lanes.
REQ-002 Parameter STAGES, default 1: output pipeline depth in clock cycles, legal range 1..4.
REQ-003 The port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 The port in_valid, input, 1 bit, SHALL qualify a and b on the current clock edge.
REQ-006 The port a, input, WIDTH bits, SHALL carry addend A, one bit per lane.
REQ-007 The port b, input, WIDTH bits, SHALL carry addend B, one bit per lane.
REQ-008 The port s, output, WIDTH bits, SHALL carry the per-lane sum.
REQ-009 The port c, output, WIDTH bits, SHALL carry the per-lane carry.
REQ-010 The port out_valid, output, 1 bit, SHALL be high when s and c hold a result.
REQ-011 The port carry_any, output, 1 bit, SHALL be the OR-reduction of c.

Function
REQ-012 Each lane i SHALL compute s[i] = a[i] XOR b[i] and c[i] = a[i] AND b[i].
REQ-013 Lanes SHALL be fully independent; there is no carry propagation between lanes.
REQ-014 Outputs SHALL appear exactly STAGES rising edges after the edge that sampled in_valid=1.
REQ-015 out_valid SHALL be in_valid delayed by STAGES cycles, with no back-pressure.
REQ-016 When in_valid=0 on an edge, stage 1 s/c SHALL hold their previous values while the valid bit shifts to 0.
REQ-017 Later stages SHALL shift the held values, so s/c are stable whenever out_valid=0 after the first result.
REQ-018 carry_any SHALL be registered in step with c; it is never a combinational path from a or b.
REQ-019 Back-to-back valid inputs SHALL produce back-to-back valid outputs at full throughput, one result per cycle.
REQ-020 Input X/Z handling is out of scope; inputs are driven 0 or 1.

Reset
REQ-021 While rst=1, s, c, out_valid and carry_any SHALL be 0 immediately, without waiting for clk.
REQ-022 All pipeline stage registers SHALL be cleared by rst; results in flight at reset assertion are discarded.
REQ-023 The first edge after rst deasserts SHALL sample inputs normally.

Structure
REQ-024 A shared package SHALL hold the STAGES bound (MAX_STAGES=4) and the reset value constant.
REQ-025 One sub-module, half_adder_lane (combinational 1-bit XOR/AND), SHALL be instantiated WIDTH times.
REQ-026 The pipeline SHALL be a generate loop of STAGES register stages inside half_adder.

Verification
REQ-027 Truth table (WIDTH=1, STAGES=1): apply a,b = 00, 01, 10, 11, each with in_valid=1 and held 10 time units -> c,s = 00, 01, 01, 10 one edge later.
REQ-028 Latency sweep STAGES=1..4: a single valid pulse a=1, b=1 -> c=1, s=0, out_valid=1 exactly STAGES edges later, lasting one cycle.
REQ-029 Multi-lane check (WIDTH=8): a=0xF0, b=0xCC -> s=0x3C, c=0xC0, carry_any=1; then a=0x0F, b=0xF0 -> c=0x00, carry_any=0.
REQ-030 Hold check: valid a=1, b=1, then in_valid=0 with a=0, b=1 -> s/c remain 0/1 and out_valid falls to 0.
REQ-031 Async reset mid-pipeline (STAGES=3): assert rst between edges while results are in flight -> all outputs 0 at once, and no stale out_valid after release.
REQ-032 Throughput check: 16 consecutive random valid vectors -> 16 consecutive correct results, with out_valid continuously high.
